// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative key schedule: key-length and
// state encodings, per-length word counts, xtime and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_BAD = 2'd3
  } key_len_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Word index width; covers the largest store (60 words).
  localparam int WIDX_W = 6;

  // Cipher key length in 32-bit words; 0 flags an illegal selection.
  function automatic logic [3:0] nk_of(input key_len_t len);
    case (len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Entry 0 sits in the top byte, so entry b lives at bit offset 8*(255-b).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/key_schedule_iter_if.sv
// Request/response bundle between key load logic and the key schedule engine.
interface key_schedule_iter_if #(parameter int MAX_NK = 8);
  import aes_pkg::*;

  // i_start is a single-cycle request with no backpressure: it is accepted
  // only in IDLE/READY, ignored during EXPAND; o_done and o_err are one-cycle
  // pulses; o_round_key is a combinational read valid while o_ready is high.
  logic                  i_start;
  logic [1:0]            i_key_len;
  logic [32*MAX_NK-1:0]  i_cypher_key;
  logic [3:0]            i_rk_addr;
  logic [127:0]          o_round_key;
  logic                  o_busy;
  logic                  o_ready;
  logic                  o_done;
  logic                  o_err;
  state_t                dbg_state;

  modport master (
    output i_start, i_key_len, i_cypher_key, i_rk_addr,
    input  o_round_key, o_busy, o_ready, o_done, o_err, dbg_state
  );

  modport slave (
    input  i_start, i_key_len, i_cypher_key, i_rk_addr,
    output o_round_key, o_busy, o_ready, o_done, o_err, dbg_state
  );

endinterface

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES key expansion: one schedule word per clock into a word store,
// round keys served by index. Define KEY_SCHED_INV_ORDER_EN for reversed reads.
module key_schedule_iter
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  key_schedule_iter_if.slave bus
);

  localparam int DEPTH = 4 * (MAX_NK + 7);

  logic [31:0] store [DEPTH];

  state_t              state_q, state_d;
  logic [3:0]          nk_q, nk_d;
  logic [3:0]          nr_q, nr_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic [2:0]          phase_q, phase_d;
  logic [7:0]          rcon_q, rcon_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                load_en, exp_en;

  key_len_t            len;
  logic [3:0]          len_nk;
  logic                start_legal;
  logic [WIDX_W-1:0]   last_idx;

  logic [31:0]         prev_w, back_w, rot_w, sub_in, sub_out, temp_w, new_w;

  assign len         = key_len_t'(bus.i_key_len);
  assign len_nk      = nk_of(len);
  assign start_legal = (len != KEY_BAD) && (int'(len_nk) <= MAX_NK);
  assign last_idx    = {nr_q, 2'b11};

  // Recurrence datapath; one shared SubWord serves both the rotated and
  // the AES-256 mid-block substitution.
  assign prev_w = store[widx_q - WIDX_W'(1)];
  assign back_w = store[widx_q - WIDX_W'(nk_q)];
  assign rot_w  = {prev_w[23:0], prev_w[31:24]};
  assign sub_in = (phase_q == 3'd0) ? rot_w : prev_w;

  aes_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  always_comb begin
    temp_w = prev_w;
    if (phase_q == 3'd0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
      temp_w = sub_out;
    end
  end

  assign new_w = back_w ^ temp_w;

  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    widx_d  = widx_q;
    phase_d = phase_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_en = 1'b0;
    exp_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (bus.i_start) begin
          if (start_legal) begin
            load_en = 1'b1;
            nk_d    = len_nk;
            nr_d    = len_nk + 4'd6;
            widx_d  = WIDX_W'(len_nk);
            phase_d = 3'd0;
            rcon_d  = 8'h01;
            state_d = ST_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        exp_en = 1'b1;
        widx_d = widx_q + WIDX_W'(1);
        // Phase counts modulo Nk so no divider is needed for i mod Nk.
        phase_d = ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (widx_q == last_idx) begin
          state_d = ST_READY;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      nk_q    <= 4'd0;
      nr_q    <= 4'd0;
      widx_q  <= '0;
      phase_q <= 3'd0;
      rcon_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      widx_q  <= widx_d;
      phase_q <= phase_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Word store carries no reset; o_ready gates every read of it.
  always_ff @(posedge i_clk) begin
    if (load_en) begin
      for (int k = 0; k < MAX_NK; k++) begin
        if (k < int'(len_nk)) begin
          store[k] <= bus.i_cypher_key[32*(MAX_NK-1-k) +: 32];
        end
      end
    end
    if (exp_en) begin
      store[widx_q] <= new_w;
    end
  end

  logic [3:0]        rd_round;
  logic [WIDX_W-1:0] rd_base;
  logic              rd_ok;

`ifdef KEY_SCHED_INV_ORDER_EN
  assign rd_round = nr_q - bus.i_rk_addr;
`else
  assign rd_round = bus.i_rk_addr;
`endif

  assign rd_base = {rd_round, 2'b00};
  assign rd_ok   = (state_q == ST_READY) && (bus.i_rk_addr <= nr_q);

  assign bus.o_round_key = rd_ok ? {store[rd_base],
                                    store[rd_base + WIDX_W'(1)],
                                    store[rd_base + WIDX_W'(2)],
                                    store[rd_base + WIDX_W'(3)]} : 128'h0;
  // Busy covers the accepting cycle so it spans the full start-to-done latency.
  assign bus.o_busy    = (state_q == ST_EXPAND) || load_en;
  assign bus.o_ready   = (state_q == ST_READY);
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Directed bench for key_schedule_iter using FIPS-197 key expansion vectors.
module tb_key_schedule_iter;
  import aes_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [127:0] exp_q[$];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] K128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] K128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] K192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] K192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] K256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] K256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] K256_3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] K256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  key_schedule_iter_if #(.MAX_NK(8)) bus ();

  key_schedule_iter #(.MAX_NK(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [1:0] len, input logic [255:0] key);
    @(posedge clk);
    #1;
    bus.i_start      = 1'b1;
    bus.i_key_len    = len;
    bus.i_cypher_key = key;
    #1;
  endtask

  // Counts edges from start until o_done; optionally injects a stray start.
  task automatic wait_done(input int stray_at, output int lat, output int busy_cnt,
                           output int err_seen, output logic rdy1, output logic [127:0] rk1);
    busy_cnt = bus.o_busy ? 1 : 0;
    err_seen = 0;
    rdy1     = 1'bx;
    rk1      = 'x;
    lat      = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      lat = n;
      bus.i_start = (n == stray_at);
      if (n == stray_at) begin
        bus.i_key_len    = 2'd2;
        bus.i_cypher_key = '1;
      end
      #1;
      if (n == 1) begin
        rdy1 = bus.o_ready;
        rk1  = bus.o_round_key;
      end
      if (bus.o_err) err_seen++;
      if (bus.o_done) break;
      if (bus.o_busy) busy_cnt++;
    end
    bus.i_start = 1'b0;
  endtask

  task automatic read_key(input int r, input int nr, output logic [127:0] k);
`ifdef KEY_SCHED_INV_ORDER_EN
    bus.i_rk_addr = 4'(nr - r);
`else
    bus.i_rk_addr = 4'(r);
`endif
    #1;
    k = bus.o_round_key;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_key_len = 2'd0;
    bus.i_cypher_key = '0;
    bus.i_rk_addr = 4'd0;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_ready, bus.o_done, bus.o_err} !== 4'b0000 || bus.o_round_key !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%h exp 0000/0",
               {bus.o_busy, bus.o_ready, bus.o_done, bus.o_err}, bus.o_round_key);
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", bus.dbg_state, ST_IDLE);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_aes128();
    int lat, bc, es, rnd[4];
    logic r1;
    logic [127:0] k1, got, exp;
    start_op(2'd0, KEY128);
    wait_done(0, lat, bc, es, r1, k1);
    checks++;
    if (lat !== 41) begin errors++; $display("FAIL aes128_latency got %0d exp 41", lat); end
    checks++;
    if (bc !== 41) begin errors++; $display("FAIL aes128_busy_cycles got %0d exp 41", bc); end
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL aes128_ready_at_done got r%b b%b exp r1 b0", bus.o_ready, bus.o_busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL aes128_done_pulse got d%b r%b exp d0 r1", bus.o_done, bus.o_ready);
    end
    rnd = '{0, 1, 2, 10};
    exp_q = {K128_0, K128_1, K128_2, K128_10};
    foreach (rnd[n]) begin
      read_key(rnd[n], 10, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL aes128_rk%0d got %h exp %h", rnd[n], got, exp); end
    end
    bus.i_rk_addr = 4'd11;
    #1;
    checks++;
    if (bus.o_round_key !== 128'h0) begin
      errors++; $display("FAIL aes128_addr11 got %h exp 0", bus.o_round_key);
    end
  endtask

  task automatic test_illegal_in_ready();
    logic [127:0] got;
    start_op(2'd3, KEY256);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_err !== 1'b1 || bus.o_ready !== 1'b1 || bus.dbg_state !== ST_READY) begin
      errors++; $display("FAIL illegal_err got e%b r%b s%0d exp e1 r1 s2", bus.o_err, bus.o_ready, bus.dbg_state);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_err !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++; $display("FAIL illegal_err_pulse got e%b d%b exp e0 d0", bus.o_err, bus.o_done);
    end
    read_key(10, 10, got);
    checks++;
    if (got !== K128_10) begin errors++; $display("FAIL illegal_keep_rk10 got %h exp %h", got, K128_10); end
  endtask

  task automatic test_aes192_restart();
    int lat, bc, es, rnd[2];
    logic r1;
    logic [127:0] k1, got, exp;
    bus.i_rk_addr = 4'd1;
    start_op(2'd1, KEY192);
    wait_done(0, lat, bc, es, r1, k1);
    checks++;
    if (r1 !== 1'b0 || k1 !== 128'h0) begin
      errors++; $display("FAIL aes192_ready_drop got r%b k%h exp r0 k0", r1, k1);
    end
    checks++;
    if (lat !== 47) begin errors++; $display("FAIL aes192_latency got %0d exp 47", lat); end
    checks++;
    if (bc !== 47) begin errors++; $display("FAIL aes192_busy_cycles got %0d exp 47", bc); end
    rnd = '{0, 1};
    exp_q = {K192_0, K192_1};
    foreach (rnd[n]) begin
      read_key(rnd[n], 12, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL aes192_rk%0d got %h exp %h", rnd[n], got, exp); end
    end
    read_key(12, 12, got);
    checks++;
    if (got !== K192_12) begin errors++; $display("FAIL aes192_rk12 got %h exp %h", got, K192_12); end
    bus.i_rk_addr = 4'd13;
    #1;
    checks++;
    if (bus.o_round_key !== 128'h0) begin
      errors++; $display("FAIL aes192_addr13 got %h exp 0", bus.o_round_key);
    end
  endtask

  task automatic test_aes256();
    int lat, bc, es, rnd[5];
    logic r1;
    logic [127:0] k1, got, exp;
    start_op(2'd2, KEY256);
    wait_done(0, lat, bc, es, r1, k1);
    checks++;
    if (lat !== 53) begin errors++; $display("FAIL aes256_latency got %0d exp 53", lat); end
    checks++;
    if (bc !== 53) begin errors++; $display("FAIL aes256_busy_cycles got %0d exp 53", bc); end
    rnd = '{0, 1, 2, 3, 14};
    exp_q = {K256_0, K256_1, K256_2, K256_3, K256_14};
    foreach (rnd[n]) begin
      read_key(rnd[n], 14, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL aes256_rk%0d got %h exp %h", rnd[n], got, exp); end
    end
    bus.i_rk_addr = 4'd15;
    #1;
    checks++;
    if (bus.o_round_key !== 128'h0) begin
      errors++; $display("FAIL aes256_addr15 got %h exp 0", bus.o_round_key);
    end
  endtask

  task automatic test_start_mid_expand();
    int lat, bc, es;
    logic r1;
    logic [127:0] k1, got;
    start_op(2'd0, KEY128);
    wait_done(10, lat, bc, es, r1, k1);
    checks++;
    if (lat !== 41 || es !== 0) begin
      errors++; $display("FAIL mid_start_ignored got lat %0d err %0d exp lat 41 err 0", lat, es);
    end
    read_key(10, 10, got);
    checks++;
    if (got !== K128_10) begin errors++; $display("FAIL mid_start_rk10 got %h exp %h", got, K128_10); end
  endtask

  task automatic test_reset_mid_expand();
    int lat, bc, es;
    logic r1;
    logic [127:0] k1, got;
    start_op(2'd2, KEY256);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
    end
    bus.i_rk_addr = 4'd0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_busy, bus.o_ready, bus.o_done, bus.o_err} !== 4'b0000 || bus.o_round_key !== 128'h0) begin
      errors++; $display("FAIL mid_reset_outputs got %b/%h exp 0000/0",
                         {bus.o_busy, bus.o_ready, bus.o_done, bus.o_err}, bus.o_round_key);
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL mid_reset_state got %0d exp %0d", bus.dbg_state, ST_IDLE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    start_op(2'd0, KEY128);
    wait_done(0, lat, bc, es, r1, k1);
    checks++;
    if (lat !== 41) begin errors++; $display("FAIL restart_latency got %0d exp 41", lat); end
    read_key(1, 10, got);
    checks++;
    if (got !== K128_1) begin errors++; $display("FAIL restart_rk1 got %h exp %h", got, K128_1); end
    read_key(10, 10, got);
    checks++;
    if (got !== K128_10) begin errors++; $display("FAIL restart_rk10 got %h exp %h", got, K128_10); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_aes128();
    test_illegal_in_ready();
    test_aes192_restart();
    test_aes256();
    test_start_mid_expand();
    test_reset_mid_expand();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
